// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_hazard_ctrl_pkg : LM/SM opcodes, FSM encoding and register-index type
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

  localparam int REG_W = 3;

  localparam logic [3:0] LM_OPC_DEF = 4'b0110;
  localparam logic [3:0] SM_OPC_DEF = 4'b0111;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LMSM = 1'b1;

  typedef logic [REG_W-1:0] reg_idx_t;

  function automatic logic [7:0] clear_bit(input logic [7:0] m, input reg_idx_t i);
    clear_bit = m & ~(8'h01 << i);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsb_pri_enc8.sv
// ============================================================================
// lsb_pri_enc8 : index of the lowest set bit of an 8-bit vector, plus any-set
// Rev 1.0
// ============================================================================
`default_nettype none

module lsb_pri_enc8
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [7:0] vec,
  output reg_idx_t   idx,
  output logic       any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = reg_idx_t'(i);
    end
  end

  assign any = |vec;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush control with load-use detection and
//                    LM/SM micro-op sequencing
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter logic [3:0] LM_OPC = LM_OPC_DEF,
  parameter logic [3:0] SM_OPC = SM_OPC_DEF
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_opcode,
  input  logic [2:0] id_rs1,
  input  logic [2:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [7:0] id_lmsm_mask,
  input  logic       ex_is_load,
  input  logic [2:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       mem_wait,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       lmsm_valid,
  output logic [2:0] lmsm_reg,
  output logic [2:0] lmsm_cnt
);

  logic [0:0] r_state, w_nxt_state;
  logic [7:0] r_mask,  w_nxt_mask;
  logic [2:0] r_cnt,   w_nxt_cnt;

  logic       w_in_lmsm;
  logic       w_is_lmsm_op;
  logic       w_is_sm;
  logic [7:0] w_enc_in;
  reg_idx_t   w_idx;
  logic       w_any;
  logic [7:0] w_remaining;
  logic       w_src1_hit;
  logic       w_src2_hit;
  logic       w_load_use;

  assign w_in_lmsm    = (r_state == ST_LMSM);
  assign w_is_sm      = (id_opcode == SM_OPC);
  assign w_is_lmsm_op = (id_opcode == LM_OPC) || w_is_sm;
  assign w_enc_in     = w_in_lmsm ? r_mask : id_lmsm_mask;
  assign w_remaining  = clear_bit(w_enc_in, w_idx);

  lsb_pri_enc8 u_enc (
    .vec (w_enc_in),
    .idx (w_idx),
    .any (w_any)
  );

  // Mid-sequence, an SM reads the register about to be stored rather than rs2.
  assign w_src1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_src2_hit = w_in_lmsm ? (w_is_sm && w_any && (w_idx == ex_rd))
                                : (id_use_rs2 && (id_rs2 == ex_rd));
  assign w_load_use = ex_is_load && (w_src1_hit || w_src2_hit);

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    lmsm_valid  = 1'b0;
    lmsm_reg    = 3'd0;
    lmsm_cnt    = 3'd0;
    w_nxt_state = r_state;
    w_nxt_mask  = r_mask;
    w_nxt_cnt   = r_cnt;

    if (mem_wait) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_nxt_state = ST_RUN;
      w_nxt_mask  = 8'h00;
      w_nxt_cnt   = 3'd0;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (w_in_lmsm) begin
      if (w_any) begin
        lmsm_valid = 1'b1;
        lmsm_reg   = w_idx;
        lmsm_cnt   = r_cnt + 3'd1;
        if (w_remaining != 8'h00) begin
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          w_nxt_mask = w_remaining;
          w_nxt_cnt  = r_cnt + 3'd1;
        end else begin
          w_nxt_state = ST_RUN;
          w_nxt_mask  = 8'h00;
          w_nxt_cnt   = 3'd0;
        end
      end else begin
        w_nxt_state = ST_RUN;
        w_nxt_cnt   = 3'd0;
      end
    end else if (w_is_lmsm_op && w_any) begin
      lmsm_valid = 1'b1;
      lmsm_reg   = w_idx;
      lmsm_cnt   = 3'd0;
      if (w_remaining != 8'h00) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        w_nxt_state = ST_LMSM;
        w_nxt_mask  = w_remaining;
        w_nxt_cnt   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_mask  <= 8'h00;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nxt_state;
      r_mask  <= w_nxt_mask;
      r_cnt   <= w_nxt_cnt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : vector table, corner sequences and random stimulus
//                       against a queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam logic [3:0] LM = 4'b0110;
  localparam logic [3:0] SM = 4'b0111;
  localparam logic [13:0] NORM = 14'b11111_00_0_000_000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_opcode;
  logic [2:0] id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2;
  logic [7:0] id_lmsm_mask;
  logic       ex_is_load;
  logic [2:0] ex_rd;
  logic       ex_branch_taken;
  logic       mem_wait;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, lmsm_valid;
  logic [2:0] lmsm_reg, lmsm_cnt;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_lmsm_mask(id_lmsm_mask),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_wait(mem_wait), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .lmsm_valid(lmsm_valid), .lmsm_reg(lmsm_reg),
    .lmsm_cnt(lmsm_cnt)
  );

  always #5 clk = ~clk;

  logic [13:0] act;
  assign act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
                id_ex_flush, lmsm_valid, lmsm_reg, lmsm_cnt};

  int checks = 0;
  int errors = 0;
  logic [13:0] last_act;
  int got_reg[$];
  int got_cnt[$];

  // Reference model: pending LM/SM registers held as a queue of indices.
  bit in_seq = 1'b0;
  int rem_q[$];
  int issued = 0;

  typedef struct {
    logic [3:0] op; logic [2:0] rs1; logic [2:0] rs2; logic u1; logic u2;
    logic [7:0] mask; logic ld; logic [2:0] rd; logic br; logic mw; logic [13:0] exp;
  } vec_t;
  vec_t tv[12];

  task chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, a, e);
    end
  endtask

  task set_in(input logic [3:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
              input logic u1, input logic u2, input logic [7:0] mask, input logic ld,
              input logic [2:0] rd, input logic br, input logic mw);
    id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_lmsm_mask = mask; ex_is_load = ld; ex_rd = rd; ex_branch_taken = br; mem_wait = mw;
  endtask

  task model_step(output logic [13:0] e);
    logic pc, ifid, fi, fe, v, allen, hz, src2;
    int r, c;
    pc = 1; ifid = 1; allen = 1; fi = 0; fe = 0; v = 0; r = 0; c = 0;
    if (mem_wait) begin
      pc = 0; ifid = 0; allen = 0;
    end else if (ex_branch_taken) begin
      fi = 1; fe = 1; in_seq = 0; rem_q.delete(); issued = 0;
    end else begin
      if (in_seq) src2 = (id_opcode == SM) && (rem_q[0] == int'(ex_rd));
      else        src2 = id_use_rs2 && (id_rs2 == ex_rd);
      hz = ex_is_load && ((id_use_rs1 && (id_rs1 == ex_rd)) || src2);
      if (hz) begin
        pc = 0; ifid = 0; fe = 1;
      end else if (in_seq) begin
        v = 1; r = rem_q.pop_front(); c = issued; issued++;
        if (rem_q.size() == 0) in_seq = 0;
        else begin pc = 0; ifid = 0; end
      end else if ((id_opcode == LM || id_opcode == SM) && id_lmsm_mask != 8'h00) begin
        for (int i = 0; i < 8; i++) if (id_lmsm_mask[i]) rem_q.push_back(i);
        v = 1; r = rem_q.pop_front(); c = 0;
        if (rem_q.size() > 0) begin in_seq = 1; issued = 1; pc = 0; ifid = 0; end
      end
    end
    if (rst) begin in_seq = 0; rem_q.delete(); issued = 0; end
    e = {pc, ifid, allen, allen, allen, fi, fe, v, 3'(r), 3'(c)};
  endtask

  // One clock: sample mid-low-phase, compare with the model, advance to next negedge.
  task cyc(input string name);
    logic [13:0] e;
    #1;
    last_act = act;
    model_step(e);
    chk(name, act, e);
    if (lmsm_valid) begin got_reg.push_back(int'(lmsm_reg)); got_cnt.push_back(int'(lmsm_cnt)); end
    @(negedge clk);
  endtask

  task idle();
    set_in(4'h0, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    tv[0]  = '{4'h1, 3'd1, 3'd2, 1, 1, 8'h00, 0, 3'd1, 0, 0, NORM};
    tv[1]  = '{4'h1, 3'd1, 3'd2, 1, 1, 8'h00, 0, 3'd1, 0, 1, 14'b00000_00_0_000_000};
    tv[2]  = '{4'h1, 3'd1, 3'd2, 1, 1, 8'h00, 0, 3'd1, 1, 0, 14'b11111_11_0_000_000};
    tv[3]  = '{4'h1, 3'd0, 3'd3, 0, 1, 8'h00, 1, 3'd3, 0, 0, 14'b00111_01_0_000_000};
    tv[4]  = '{4'h1, 3'd0, 3'd3, 0, 0, 8'h00, 1, 3'd3, 0, 0, NORM};
    tv[5]  = '{4'h1, 3'd5, 3'd0, 1, 0, 8'h00, 1, 3'd5, 0, 0, 14'b00111_01_0_000_000};
    tv[6]  = '{LM,   3'd0, 3'd0, 0, 0, 8'hA4, 0, 3'd0, 0, 0, 14'b00111_00_1_010_000};
    tv[7]  = '{LM,   3'd0, 3'd0, 0, 0, 8'h00, 0, 3'd0, 0, 0, NORM};
    tv[8]  = '{SM,   3'd0, 3'd0, 0, 0, 8'h80, 0, 3'd0, 0, 0, 14'b11111_00_1_111_000};
    tv[9]  = '{4'h1, 3'd0, 3'd0, 0, 0, 8'h00, 0, 3'd0, 1, 1, 14'b00000_00_0_000_000};
    tv[10] = '{4'h1, 3'd4, 3'd0, 1, 0, 8'h00, 1, 3'd4, 1, 0, 14'b11111_11_0_000_000};
    tv[11] = '{LM,   3'd6, 3'd0, 1, 0, 8'h0F, 1, 3'd6, 0, 0, 14'b00111_01_0_000_000};

    idle(); rst = 1'b1;
    @(negedge clk);
    cyc("reset_hold");
    rst = 1'b0;
    cyc("after_reset");
    chk("reset_state_normal", last_act, NORM);

    for (int k = 0; k < 12; k++) begin
      idle(); rst = 1'b1; cyc("tbl_rst");
      rst = 1'b0;
      set_in(tv[k].op, tv[k].rs1, tv[k].rs2, tv[k].u1, tv[k].u2, tv[k].mask,
             tv[k].ld, tv[k].rd, tv[k].br, tv[k].mw);
      cyc("tbl_model");
      chk($sformatf("tbl_vec%0d", k), last_act, tv[k].exp);
    end
    idle(); rst = 1'b1; cyc("seq_rst"); rst = 1'b0;

    // Load-use: exactly one bubble, then normal run once EX carries the bubble.
    set_in(4'h1, 3'd0, 3'd3, 1'b0, 1'b1, 8'h00, 1'b1, 3'd3, 1'b0, 1'b0);
    cyc("lu_stall");
    chk("lu_stall_fields", {last_act[13], last_act[7]}, 2'b01);
    set_in(4'h1, 3'd0, 3'd3, 1'b0, 1'b1, 8'h00, 1'b0, 3'd3, 1'b0, 1'b0);
    cyc("lu_next");
    chk("lu_next_normal", last_act, NORM);

    // LM 1010_0100 -> regs 2,5,7.
    set_in(LM, 3'd0, 3'd0, 1'b0, 1'b0, 8'hA4, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc("lm_a4_0"); chk("lm_a4_0_f", {last_act[6:0], last_act[13]}, {1'b1, 3'd2, 3'd0, 1'b0});
    cyc("lm_a4_1"); chk("lm_a4_1_f", {last_act[6:0], last_act[13]}, {1'b1, 3'd5, 3'd1, 1'b0});
    cyc("lm_a4_2"); chk("lm_a4_2_f", {last_act[6:0], last_act[13]}, {1'b1, 3'd7, 3'd2, 1'b1});
    idle(); cyc("lm_a4_after");

    // SM 0xFF with a 2-cycle mem_wait mid-sequence.
    got_reg.delete(); got_cnt.delete();
    for (int k = 0; k < 10; k++) begin
      set_in(SM, 3'd0, 3'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, (k == 3 || k == 4));
      cyc("sm_ff");
    end
    chk("sm_ff_last_pc_en", last_act[13], 1'b1);
    chk("sm_ff_count", got_reg.size(), 8);
    for (int i = 0; i < 8 && i < got_reg.size(); i++) begin
      chk($sformatf("sm_ff_reg%0d", i), got_reg[i], i);
      chk($sformatf("sm_ff_cnt%0d", i), got_cnt[i], i);
    end
    idle(); cyc("sm_ff_after");

    // Branch after two LM issues.
    set_in(LM, 3'd0, 3'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc("br_lm0"); cyc("br_lm1");
    set_in(LM, 3'd0, 3'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b0);
    cyc("br_hit");
    chk("br_hit_fields", {last_act[8:6]}, 3'b110);
    idle(); cyc("br_next");
    chk("br_next_normal", last_act, NORM);

    // Reset in the middle of a sequence.
    set_in(LM, 3'd0, 3'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc("rs_lm0"); cyc("rs_lm1");
    rst = 1'b1; cyc("rs_rst"); rst = 1'b0;
    idle(); cyc("rs_next");
    chk("rs_next_normal", last_act, NORM);
    set_in(LM, 3'd0, 3'd0, 1'b0, 1'b0, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc("rs_fresh");
    chk("rs_fresh_lm01", last_act, 14'b11111_00_1_000_000);

    // LM with empty mask.
    set_in(LM, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc("lm00");
    chk("lm00_normal", last_act, NORM);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 3);
      id_opcode    = (sel == 0) ? LM : (sel == 1) ? SM : 4'($urandom);
      id_rs1       = 3'($urandom); id_rs2 = 3'($urandom);
      id_use_rs1   = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_lmsm_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ex_is_load   = ($urandom_range(0, 3) == 0);
      ex_rd        = 3'($urandom);
      ex_branch_taken = ($urandom_range(0, 11) == 0);
      mem_wait     = ($urandom_range(0, 7) == 0);
      rst          = ($urandom_range(0, 59) == 0);
      cyc("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
